// File: rtl/snake_pkg.sv
// Shared constants for the snake pixel pipeline: cell codes, 12-bit RGB
// colours and board geometry defaults.
package snake_pkg;

  localparam int CELL_SHIFT   = 4;
  localparam int GRID_W       = 40;
  localparam int GRID_H       = 30;
  localparam int FLASH_FRAMES = 15;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BODY  = 2'b01;
  localparam logic [1:0] CELL_HEAD  = 2'b10;
  localparam logic [1:0] CELL_FOOD  = 2'b11;

  localparam logic [11:0] COL_BLACK = 12'h000;
  localparam logic [11:0] COL_BG    = 12'h020;
  localparam logic [11:0] COL_BODY  = 12'h0F0;
  localparam logic [11:0] COL_HEAD  = 12'hFF0;
  localparam logic [11:0] COL_FOOD  = 12'hF00;
  localparam logic [11:0] COL_WALL  = 12'h888;
  localparam logic [11:0] COL_GRID  = 12'h111;

endpackage

// File: rtl/snake_pixel_gen_if.sv
// Beam-in / board-RAM / VGA-out signal bundle for snake_pixel_gen.
// slave = the pixel generator, master = whoever drives the beam and RAM data.
interface snake_pixel_gen_if #(
  parameter int ADDR_W = 11
);
  logic [9:0]        x;
  logic [9:0]        y;
  logic              hsync_in;
  logic              vsync_in;
  logic              visible_in;
  logic              game_over;
  logic [ADDR_W-1:0] cell_addr;
  logic [1:0]        cell_data;
  logic [3:0]        red;
  logic [3:0]        green;
  logic [3:0]        blue;
  logic              hsync;
  logic              vsync;
  logic              frame_tick;

  modport master (
    output x, y, hsync_in, vsync_in, visible_in, game_over, cell_data,
    input  cell_addr, red, green, blue, hsync, vsync, frame_tick
  );

  modport slave (
    input  x, y, hsync_in, vsync_in, visible_in, game_over, cell_data,
    output cell_addr, red, green, blue, hsync, vsync, frame_tick
  );
endinterface

// File: rtl/snake_flash_ctrl.sv
// Frame tick (falling edge of vsync_in) and game-over flash phase generator.
// The phase flips every FLASH_FRAMES ticks while game_over is held high.
module snake_flash_ctrl
  import snake_pkg::*;
#(
  parameter int FLASH_FRAMES = snake_pkg::FLASH_FRAMES
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync_in,
  input  logic game_over,
  output logic frame_tick,
  output logic flash_phase
);
  localparam int CNT_W = $clog2(FLASH_FRAMES + 1);

  logic             vs_prev;
  logic             armed;
  logic [CNT_W-1:0] flash_cnt;

  // Registered vsync falling-edge detect; armed blocks a false edge right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev    <= 1'b1;
      armed      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vs_prev    <= vsync_in;
      armed      <= 1'b1;
      frame_tick <= armed & vs_prev & ~vsync_in;
    end
  end

  // Flash frame counter; dropping game_over clears it even on a tick cycle.
  always_ff @(posedge clk) begin
    if (rst || !game_over) begin
      flash_cnt   <= '0;
      flash_phase <= 1'b0;
    end else if (frame_tick) begin
      if (flash_cnt == CNT_W'(FLASH_FRAMES - 1)) begin
        flash_cnt   <= '0;
        flash_phase <= ~flash_phase;
      end else begin
        flash_cnt <= flash_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/snake_pixel_gen.sv
// Snake pixel colour stage: maps beam position to a board cell, reads the
// cell code from board RAM and emits RGB with 2-cycle-matched syncs.
// Optional: define SNAKE_GRID_LINES_EN to draw a 111 grid over empty cells.
module snake_pixel_gen
  import snake_pkg::*;
#(
  parameter int CELL_SHIFT   = snake_pkg::CELL_SHIFT,
  parameter int GRID_W       = snake_pkg::GRID_W,
  parameter int GRID_H       = snake_pkg::GRID_H,
  parameter int ADDR_W       = 11,
  parameter int FLASH_FRAMES = snake_pkg::FLASH_FRAMES
) (
  input logic              clk,
  input logic              rst,
  snake_pixel_gen_if.slave bus
);
  localparam int CW = 10 - CELL_SHIFT;

  logic [CW-1:0]     col;
  logic [CW-1:0]     row;
  logic [ADDR_W-1:0] col_w;
  logic [ADDR_W-1:0] row_w;
  logic [ADDR_W-1:0] addr_next;
  logic              wall_next;

  logic [ADDR_W-1:0] addr_q;
  logic              wall_q;
  logic              vis_q;
  logic              hs_q1;
  logic              vs_q1;
  logic              hs_q2;
  logic              vs_q2;
  logic [11:0]       rgb_q;
  logic [11:0]       pix;
  logic              frame_tick_w;
  logic              flash_phase;
  logic              flash_on;

  assign col   = bus.x[9:CELL_SHIFT];
  assign row   = bus.y[9:CELL_SHIFT];
  assign col_w = ADDR_W'(col);
  assign row_w = ADDR_W'(row);

  // row*40 as two shifts; blanked beam positions read cell 0 to stay in range
  assign addr_next = bus.visible_in ? (row_w << 5) + (row_w << 3) + col_w : '0;
  assign wall_next = (col == CW'(0)) || (col == CW'(GRID_W - 1)) ||
                     (row == CW'(0)) || (row == CW'(GRID_H - 1));

`ifdef SNAKE_GRID_LINES_EN
  logic grid_next;
  logic grid_q;
  assign grid_next = (bus.x[CELL_SHIFT-1:0] == '0) || (bus.y[CELL_SHIFT-1:0] == '0);

  // Carry the cell-offset flag alongside the address stage.
  always_ff @(posedge clk) begin
    if (rst) grid_q <= 1'b0;
    else     grid_q <= grid_next;
  end
`endif

  assign flash_on = bus.game_over & flash_phase;

  // Colour select for the pixel whose cell data is arriving this cycle.
  always_comb begin
    pix = COL_BLACK;
    if (!vis_q) begin
      pix = COL_BLACK;
    end else if (wall_q) begin
      pix = COL_WALL;
    end else begin
      case (bus.cell_data)
        CELL_EMPTY: begin
          pix = COL_BG;
`ifdef SNAKE_GRID_LINES_EN
          if (grid_q) pix = COL_GRID;
`endif
        end
        CELL_BODY: pix = flash_on ? COL_FOOD : COL_BODY;
        CELL_HEAD: pix = flash_on ? COL_FOOD : COL_HEAD;
        default:   pix = COL_FOOD;
      endcase
    end
  end

  // Two-stage pipeline: address/flags, then colour, with syncs riding along.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      wall_q <= 1'b0;
      vis_q  <= 1'b0;
      hs_q1  <= 1'b1;
      vs_q1  <= 1'b1;
      hs_q2  <= 1'b1;
      vs_q2  <= 1'b1;
      rgb_q  <= '0;
    end else begin
      addr_q <= addr_next;
      wall_q <= wall_next;
      vis_q  <= bus.visible_in;
      hs_q1  <= bus.hsync_in;
      vs_q1  <= bus.vsync_in;
      hs_q2  <= hs_q1;
      vs_q2  <= vs_q1;
      rgb_q  <= pix;
    end
  end

  snake_flash_ctrl #(
    .FLASH_FRAMES(FLASH_FRAMES)
  ) u_flash (
    .clk        (clk),
    .rst        (rst),
    .vsync_in   (bus.vsync_in),
    .game_over  (bus.game_over),
    .frame_tick (frame_tick_w),
    .flash_phase(flash_phase)
  );

  assign bus.cell_addr  = addr_q;
  assign bus.red        = rgb_q[11:8];
  assign bus.green      = rgb_q[7:4];
  assign bus.blue       = rgb_q[3:0];
  assign bus.hsync      = hs_q2;
  assign bus.vsync      = vs_q2;
  assign bus.frame_tick = frame_tick_w;
endmodule

// File: tb/tb_snake_pixel_gen.sv
// Directed bench for snake_pixel_gen: vector table for address/colour,
// plus hand-written sequences for frame tick, flash phase and reset.
module tb_snake_pixel_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snake_pixel_gen_if #(.ADDR_W(11)) bus ();
  snake_pixel_gen dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef SNAKE_GRID_LINES_EN
  localparam bit GL = 1'b1;
`else
  localparam bit GL = 1'b0;
`endif

  // Board RAM model: data for the issued address is presented during the next cycle.
  logic [1:0] ram [0:1199];
  assign bus.cell_data = (bus.cell_addr < 11'd1200) ? ram[bus.cell_addr] : 2'b00;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        vis;
    logic        go;
    logic [1:0]  cd;
    logic [10:0] addr;
    logic [11:0] rgb;
  } vec_t;

  vec_t vecs [15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [9:0] xv, input logic [9:0] yv, input logic vis,
                       input logic go, input logic hs, input logic vs);
    bus.x          = xv;
    bus.y          = yv;
    bus.visible_in = vis;
    bus.game_over  = go;
    bus.hsync_in   = hs;
    bus.vsync_in   = vs;
  endtask

  task automatic frame_pulse(output logic got);
    bus.vsync_in = 1'b0;
    step();
    got = bus.frame_tick;
    bus.vsync_in = 1'b1;
    step();
    step();
    step();
  endtask

  function automatic logic [31:0] rgb_now();
    return {20'd0, bus.red, bus.green, bus.blue};
  endfunction

  initial begin
    int ticks;
    logic hs_h, vs_h, vis_h, have_prev, got;
    int mcnt;
    bit mph;

    for (int i = 0; i < 1200; i++) ram[i] = 2'b00;

    vecs[0]  = '{"head_122",     10'd37,  10'd50,  1'b1, 1'b0, 2'd2, 11'd122,  12'hFF0};
    vecs[1]  = '{"wall_1199_e",  10'd639, 10'd479, 1'b1, 1'b0, 2'd0, 11'd1199, 12'h888};
    vecs[2]  = '{"wall_1199_b",  10'd639, 10'd479, 1'b1, 1'b0, 2'd1, 11'd1199, 12'h888};
    vecs[3]  = '{"invisible",    10'd700, 10'd100, 1'b0, 1'b0, 2'd3, 11'd0,    12'h000};
    vecs[4]  = '{"body_122",     10'd37,  10'd50,  1'b1, 1'b0, 2'd1, 11'd122,  12'h0F0};
    vecs[5]  = '{"food_122",     10'd37,  10'd50,  1'b1, 1'b0, 2'd3, 11'd122,  12'hF00};
    vecs[6]  = '{"empty_122",    10'd37,  10'd50,  1'b1, 1'b0, 2'd0, 11'd122,  12'h020};
    vecs[7]  = '{"wall_col0",    10'd0,   10'd200, 1'b1, 1'b0, 2'd2, 11'd480,  12'h888};
    vecs[8]  = '{"body_60",      10'd320, 10'd16,  1'b1, 1'b0, 2'd1, 11'd60,   12'h0F0};
    vecs[9]  = '{"grid_x32",     10'd32,  10'd40,  1'b1, 1'b0, 2'd0, 11'd82,   GL ? 12'h111 : 12'h020};
    vecs[10] = '{"nogrid_x33",   10'd33,  10'd40,  1'b1, 1'b0, 2'd0, 11'd82,   12'h020};
    vecs[11] = '{"body_x32",     10'd32,  10'd40,  1'b1, 1'b0, 2'd1, 11'd82,   12'h0F0};
    vecs[12] = '{"wall_row29",   10'd100, 10'd470, 1'b1, 1'b0, 2'd3, 11'd1166, 12'h888};
    vecs[13] = '{"wall_col39",   10'd624, 10'd100, 1'b1, 1'b0, 2'd1, 11'd279,  12'h888};
    vecs[14] = '{"head_go_ph0",  10'd37,  10'd50,  1'b1, 1'b1, 2'd2, 11'd122,  12'hFF0};

    // reset state
    drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    step();
    step();
    chk("rst_rgb",   rgb_now(), 32'h0);
    chk("rst_hsync", {31'd0, bus.hsync}, 32'd1);
    chk("rst_vsync", {31'd0, bus.vsync}, 32'd1);
    chk("rst_tick",  {31'd0, bus.frame_tick}, 32'd0);
    chk("rst_addr",  {21'd0, bus.cell_addr}, 32'd0);
    rst = 1'b0;

    // shortened frame: 20 px per line, 12 lines, vsync low on line 10
    ticks = 0;
    have_prev = 1'b0;
    hs_h = 1'b1; vs_h = 1'b1; vis_h = 1'b0;
    for (int l = 0; l < 12; l++) begin
      for (int p = 0; p < 20; p++) begin
        logic [9:0] xv, yv;
        logic vis, hs, vs;
        xv  = 10'(p * 40);
        yv  = 10'(l * 50);
        vis = (xv < 10'd640) && (yv < 10'd480);
        hs  = !(p >= 16 && p < 18);
        vs  = (l != 10);
        drive(xv, yv, vis, 1'b0, hs, vs);
        step();
        if (bus.frame_tick) ticks++;
        if (have_prev) begin
          chk("frame_hsync_dly", {31'd0, bus.hsync}, {31'd0, hs_h});
          chk("frame_vsync_dly", {31'd0, bus.vsync}, {31'd0, vs_h});
          if (!vis_h) chk("frame_blank_rgb", rgb_now(), 32'h0);
        end
        hs_h = hs; vs_h = vs; vis_h = vis; have_prev = 1'b1;
      end
    end
    chk("frame_tick_count", ticks, 1);

    // address / colour vector table
    for (int i = 0; i < 15; i++) begin
      ram[vecs[i].addr] = vecs[i].cd;
      drive(vecs[i].x, vecs[i].y, vecs[i].vis, vecs[i].go, 1'b1, 1'b1);
      step();
      chk({vecs[i].name, "_addr"}, {21'd0, bus.cell_addr}, {21'd0, vecs[i].addr});
      step();
      chk({vecs[i].name, "_rgb"}, rgb_now(), {20'd0, vecs[i].rgb});
    end

    // game-over flash over a body cell
    ram[122] = 2'd1;
    drive(10'd37, 10'd50, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    step();
    bus.game_over = 1'b1;
    step();
    step();
    chk("flash_start", rgb_now(), 32'h0F0);
    mcnt = 0;
    mph  = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      frame_pulse(got);
      chk("flash_tick", {31'd0, got}, 32'd1);
      if (mcnt == 14) begin mcnt = 0; mph = ~mph; end
      else mcnt++;
      chk("flash_rgb", rgb_now(), mph ? 32'hF00 : 32'h0F0);
    end

    // game_over drops on the tick cycle: clear must win
    bus.vsync_in = 1'b0;
    step();
    chk("coinc_tick", {31'd0, bus.frame_tick}, 32'd1);
    bus.game_over = 1'b0;
    bus.vsync_in  = 1'b1;
    step();
    bus.game_over = 1'b1;
    step();
    step();
    chk("coinc_clear_wins", rgb_now(), 32'h0F0);
    mcnt = 0;
    mph  = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      frame_pulse(got);
      if (mcnt == 14) begin mcnt = 0; mph = ~mph; end
      else mcnt++;
    end
    chk("phase_before_rst", rgb_now(), mph ? 32'hF00 : 32'h0F0);

    // mid-line reset with syncs driven low
    bus.hsync_in = 1'b0;
    bus.vsync_in = 1'b0;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("mid_rst_hsync", {31'd0, bus.hsync}, 32'd1);
      chk("mid_rst_vsync", {31'd0, bus.vsync}, 32'd1);
      chk("mid_rst_rgb",   rgb_now(), 32'h0);
      chk("mid_rst_tick",  {31'd0, bus.frame_tick}, 32'd0);
      chk("mid_rst_addr",  {21'd0, bus.cell_addr}, 32'd0);
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("post_rst_no_tick", {31'd0, bus.frame_tick}, 32'd0);
    end
    chk("post_rst_phase0", rgb_now(), 32'h0F0);
    chk("post_rst_hsync",  {31'd0, bus.hsync}, 32'd0);
    bus.vsync_in = 1'b1;
    step();
    frame_pulse(got);
    chk("post_rst_tick", {31'd0, got}, 32'd1);
    chk("post_rst_cnt1", rgb_now(), 32'h0F0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/snake_pixel_gen.md
Name: snake_pixel_gen

Overview:
- Pixel-colour stage directly downstream of the VGA timing generator.
- Consumes the raw beam position `x`/`y`, `hsync`, `vsync` and `visible`, and maps the pixel to a 16x16-pixel board cell.
- Reads the cell type from the board RAM (synchronous, 1-cycle read) and emits 12-bit RGB plus delay-matched sync signals to the VGA pins.
- Also generates a once-per-frame tick for game logic and the game-over flash effect.

Parameters:
- CELL_SHIFT, 4, log2 of cell size in pixels (16 px cells).
- GRID_W, 40, board columns.
- GRID_H, 30, board rows.
- ADDR_W, 11, board RAM address width (covers 0..1199).
- FLASH_FRAMES, 15, frames per game-over flash phase.

Ports:
- clk  in  1  25 MHz pixel clock
- rst  in  1  synchronous reset, active-high
- x  in  10  beam column from timing stage
- y  in  10  beam row from timing stage
- hsync_in  in  1  active-low hsync from timing stage
- vsync_in  in  1  active-low vsync from timing stage
- visible_in  in  1  pixel inside 640x480
- game_over  in  1  level, from game FSM
- cell_addr  out  ADDR_W  board RAM read address
- cell_data  in  2  board RAM data, valid 1 cycle after cell_addr
- red  out  4  pixel red
- green  out  4  pixel green
- blue  out  4  pixel blue
- hsync  out  1  delayed hsync to pin
- vsync  out  1  delayed vsync to pin
- frame_tick  out  1  one-cycle pulse per frame

Behaviour:
- One clock domain; all state updates on posedge clk; rst is synchronous, active-high.
- Reset values: red/green/blue = 0; hsync = vsync = 1; frame_tick = 0; cell_addr = 0; flash counter = 0; flash phase = 0; all pipeline registers = 0, except sync pipeline registers = 1.
- Pipeline is 2 cycles, and all outputs are aligned to it.
  - S0: register cell_addr and the col/row/edge flags.
  - S1: cell_data is valid.
  - S2: register the colour.
- hsync_in, vsync_in and visible_in are delayed by exactly 2 registers, so RGB and sync for one pixel leave on the same cycle.
- Address computation:
  - col = x >> CELL_SHIFT, row = y >> CELL_SHIFT.
  - cell_addr = row*40 + col, implemented as (row<<5)+(row<<3)+col, with no multiplier.
  - When visible_in = 0, cell_addr = 0, so the address is never out of range (x up to 799 would give col 49).
- Cell codes: 00 empty, 01 body, 10 head, 11 food.
- Colour priority at S2:
  1. Delayed visible = 0: RGB = 000.
  2. Edge cell (col 0, col GRID_W-1, row 0 or row GRID_H-1): wall colour 888, regardless of cell_data.
  3. Otherwise by cell code:
     - empty: 020
     - body: 0F0
     - head: FF0
     - food: F00
  4. If game_over = 1 and flash phase = 1: body and head become F00; food and empty are unchanged.
- frame_tick:
  - Pulses high for one cycle on the cycle after vsync_in falls (registered edge detect of the input, 1→0).
  - Exactly one pulse per 525-line frame.
  - No pulse on the first cycle after reset, even if vsync_in = 0.
- Flash counter:
  - Counts frame_ticks while game_over = 1 and wraps FLASH_FRAMES-1 → 0.
  - Flash phase toggles on each wrap.
  - When game_over = 0, counter and phase are held at 0.
  - If game_over falls on the same cycle as a frame_tick, the clear wins.
- Reset mid-frame: all outputs return to reset values on the next edge. After reset releases, outputs are valid 2 cycles after the first post-reset input.

Optional Feature:
- Macro: SNAKE_GRID_LINES_EN.
- Defined: for a visible, non-wall pixel with empty cell code, pixel row or column offset within the cell equal to 0 (x[CELL_SHIFT-1:0] == 0 or y[CELL_SHIFT-1:0] == 0) outputs 111 instead of 020.
  - The offset bits are carried through the pipeline alongside col/row.
  - Occupied cells and wall cells are unaffected.
- Not defined: no grid lines; offset bits are not pipelined.

Decomposition:
- Shared package snake_pkg holds:
  - cell code constants CELL_EMPTY, CELL_BODY, CELL_HEAD, CELL_FOOD;
  - 12-bit colour constants COL_BG, COL_BODY, COL_HEAD, COL_FOOD, COL_WALL, COL_GRID;
  - GRID_W, GRID_H, CELL_SHIFT defaults.
- One natural sub-module: snake_flash_ctrl, containing the frame_tick edge detect plus the flash counter/phase; outputs frame_tick and flash_phase.
- The address math and the colour mux stay in the top module.

Test Plan:
- Reset, then a full frame of timing stimulus: exactly one frame_tick, 2 cycles of sync delay versus inputs, RGB = 000 whenever delayed visible = 0.
- x = 37, y = 50, visible = 1: cell_addr = 3*40+2 = 122 after 1 cycle; RAM model returns 10 → RGB FF0 at the output 2 cycles after input.
- x = 639, y = 479: cell_addr = 29*40+39 = 1199; output 888 (wall) for any cell_data. x = 700, visible = 0: cell_addr = 0.
- game_over = 1 across 31 frame_ticks with body cell: 15 frames 0F0, 15 frames F00, then 0F0 again. game_over dropped coincident with a tick: phase = 0 on the next frame.
- rst asserted mid-line for 3 cycles: hsync = vsync = 1, RGB = 0, counter = 0. After release, no spurious frame_tick.
- With SNAKE_GRID_LINES_EN: empty cell at x = 32 gives 111 and x = 33 gives 020; body cell at x = 32 gives 0F0.
